// File: rtl/oldland_bus_pkg.sv
// Definitions shared by the Oldland instruction- and data-bus bridges:
// state encoding, request field widths and the captured-request record.
package oldland_bus_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } bus_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SEL_W-1:0]  bytesel;
        logic              wr_en;
        logic [DATA_W-1:0] wr_val;
    } bus_req_t;

endpackage

// File: rtl/oldland_timeout_counter.sv
// Saturating cycle counter that flags the cycle in which it reaches LIMIT-1.
// A LIMIT of 0 disables the counter entirely.
module oldland_timeout_counter #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned    CNT_W    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: reset is synchronous, so it is sampled inside the clocked block
    // like any other input rather than appearing in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && en && (count == CNT_LAST);

endmodule

// File: rtl/oldland_dbus_bridge.sv
// Registered bridge from the memory-stage data port to the system data bus.
// One access in flight; completes with a one-cycle d_ack, d_error on fault/timeout.
module oldland_dbus_bridge
    import oldland_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_access,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [SEL_W-1:0]  d_bytesel,
    input  logic              d_wr_en,
    input  logic [DATA_W-1:0] d_wr_val,
    output logic [DATA_W-1:0] d_data,
    output logic              d_ack,
    output logic              d_error,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ADDR_W-1:0] b_addr,
    output logic [SEL_W-1:0]  b_bytesel,
    output logic              b_wr_en,
    output logic [DATA_W-1:0] b_wr_val,
    input  logic              b_rvalid,
    input  logic [DATA_W-1:0] b_rdata,
    input  logic              b_err
);

    bus_state_t        state;
    bus_state_t        state_nxt;
    bus_req_t          req_q;
    logic              stale;
    logic              stale_nxt;
    logic              capture;
    logic              resp_err_nxt;
    logic [DATA_W-1:0] resp_data_nxt;
    logic              timeout;
    logic              stale_expired;

    oldland_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_txn_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == IDLE),
        .en      ((state == REQ) || (state == WAIT)),
        .expired (timeout)
    );

    // Drains an abandoned response: stale gives up after another full timeout.
    oldland_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_stale_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!stale),
        .en      (stale),
        .expired (stale_expired)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_nxt     = state;
        stale_nxt     = stale;
        capture       = 1'b0;
        resp_err_nxt  = 1'b0;
        resp_data_nxt = '0;

        case (state)
            IDLE: begin
                if (d_access && !stale) begin
                    capture   = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (b_ready) begin
                    state_nxt = WAIT;
                end else if (timeout) begin
                    state_nxt    = RESP;
                    resp_err_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (b_rvalid) begin
                    state_nxt     = RESP;
                    resp_err_nxt  = b_err;
                    resp_data_nxt = b_err ? '0 : b_rdata;
                end else if (timeout) begin
                    state_nxt    = RESP;
                    resp_err_nxt = 1'b1;
                    stale_nxt    = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // The response owed to a timed-out access is swallowed here, never forwarded.
        if (stale && (b_rvalid || stale_expired)) begin
            stale_nxt = 1'b0;
        end
    end

    // Outputs are registered from the next-state decode so d_* never sees b_* combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            stale   <= 1'b0;
            req_q   <= '0;
            b_valid <= 1'b0;
            d_ack   <= 1'b0;
            d_error <= 1'b0;
            d_data  <= '0;
        end else begin
            state   <= state_nxt;
            stale   <= stale_nxt;
            b_valid <= (state_nxt == REQ);
            d_ack   <= (state_nxt == RESP);
            d_error <= resp_err_nxt;
            d_data  <= resp_data_nxt;
            if (capture) begin
                req_q <= '{addr: d_addr, bytesel: d_bytesel, wr_en: d_wr_en, wr_val: d_wr_val};
            end
        end
    end

    assign b_addr    = req_q.addr;
    assign b_bytesel = req_q.bytesel;
    assign b_wr_en   = req_q.wr_en;
    assign b_wr_val  = req_q.wr_val;

endmodule

// File: doc/oldland_dbus_bridge.md
# oldland_dbus_bridge

Registered bridge between the memory stage's data-bus request port and the system data bus. It captures one CPU data access, issues it to the bus with a valid/ready handshake, waits for the response and returns `d_ack` (and `d_error` on fault or timeout) with aligned read data. Downstream of the memory stage on the `d_*` signals, upstream of the bus interconnect. At most one transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles from capture to forced error response; 0 disables timeout.
- `clk  in  1`: core clock; all state changes on rising edge.
- `rst_n  in  1`: synchronous, active-low reset.
- `d_access  in  1`: memory-stage access request; level, held until `d_ack`.
- `d_addr  in  32`: word-aligned address, bits [1:0] are zero.
- `d_bytesel  in  4`: byte enables.
- `d_wr_en  in  1`: 1 = store, 0 = load.
- `d_wr_val  in  32`: lane-rotated store data.
- `d_data  out  32`: read data; valid only while `d_ack` is high.
- `d_ack  out  1`: one-cycle completion pulse.
- `d_error  out  1`: asserted with `d_ack` on bus error or timeout.
- `b_valid  out  1`: bus request valid.
- `b_ready  in  1`: bus accepts the request.
- `b_addr`, `b_bytesel`, `b_wr_en`, `b_wr_val`  `out  32/4/1/32`: registered copies of the captured request.
- `b_rvalid  in  1`: response valid; one pulse per accepted request, loads and stores alike.
- `b_rdata  in  32`: response data.
- `b_err  in  1`: response error, qualified by `b_rvalid`.

## Operation
- States:
  - IDLE: if `d_access` and not `stale`, capture the request into `b_*`, clear the counter, go to REQ.
  - REQ: `b_valid`=1. On `b_ready`, go to WAIT. On timeout, go to RESP with error.
  - WAIT: on `b_rvalid`, register `b_rdata` and `b_err`, go to RESP. On timeout, go to RESP with error and set `stale`.
  - RESP: `d_ack`=1, `d_error`=registered error, `d_data`=registered data (0 on error or timeout). Go to IDLE.
- `d_access` is sampled only in IDLE. A level still high in the cycle after `d_ack` is treated as a new request. The memory stage guarantees this level belongs to the next instruction.
- Timeout counter:
  - Width is $clog2(TIMEOUT_CYCLES+1). It increments every cycle in REQ and WAIT and saturates.
  - Timeout fires when counter == TIMEOUT_CYCLES-1.
  - A timeout in REQ drops `b_valid` the next cycle. The request was never accepted, so `stale` stays 0.
- `stale` flag:
  - Set when a timeout fires in WAIT.
  - Cleared by the next `b_rvalid`, whose response is discarded, or after TIMEOUT_CYCLES further cycles.
  - While `stale` is set, IDLE does not accept new requests.
- In REQ, `b_*` outputs hold stable until `b_ready`.
- `b_rvalid` outside WAIT with `stale`=0 is a protocol violation. It is ignored.
- If `b_ready` and timeout occur in the same cycle in REQ, `b_ready` wins: go to WAIT.
- If `b_rvalid` and timeout occur in the same cycle in WAIT, `b_rvalid` wins: normal response, `stale` stays 0.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, `stale` 0.
- Reset mid-transaction abandons the transaction. No `d_ack` is produced, and `b_valid` is low on the first cycle after the reset edge.
- Minimum latency: `d_access` high in IDLE at cycle 0; `b_valid` at cycle 1; `b_ready` at cycle 1; `b_rvalid` at cycle 2; `d_ack` at cycle 3.
- Back-to-back throughput: one access per 4 cycles minimum.
- Every output is driven from a register. There is no combinational path from `b_*` inputs to `d_*` outputs.

## Structure
- `oldland_bus_pkg`:
  - state encoding localparams: IDLE=0, REQ=1, WAIT=2, RESP=3;
  - bus request field widths, shared with the instruction-bus bridge.
- Sub-module `oldland_timeout_counter`:
  - inputs: `clr`, `en`, limit parameter;
  - outputs: `expired`;
  - instantiated twice, once for the transaction timeout and once for the `stale` drain.

## Test plan
- Load to 0x00001000, `b_ready` immediate, `b_rdata`=0xDEADBEEF at cycle 2 -> `d_ack` at cycle 3, `d_data`=0xDEADBEEF, `d_error`=0.
- Store to 0x2004 with bytesel 4'b1100 and value 0x12340000, `b_ready` delayed 5 cycles -> `b_*` stable throughout; `d_ack` 2 cycles after `b_ready`.
- TIMEOUT_CYCLES=8, `b_ready` never asserted -> `d_ack`+`d_error` at cycle 9, `d_data`=0, `b_valid` low afterwards, next request accepted immediately.
- TIMEOUT_CYCLES=8, accepted, `b_rvalid` at cycle 12 -> error ack at cycle 9; the late response is dropped, `stale` is cleared, and the next request issues on the following cycle.
- `b_rvalid` with `b_err`=1 -> `d_ack`=1, `d_error`=1, `d_data`=0.
- `rst_n` low while in WAIT -> all outputs 0 next cycle, no `d_ack`, state IDLE.
